// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings and FSM states shared by the multiply/divide unit.
// MUL_ITER_EN adds the iterative-multiply states.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        DIV_BUSY,
`ifdef MUL_ITER_EN
        DIV_DONE,
        MUL_BUSY,
        MUL_DONE
`else
        DIV_DONE
`endif
    } state_t;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// muldiv_unit_div_core: restoring-divide datapath, one quotient bit per step.
// With MUL_ITER_EN the same registers also run a right-shifting shift-add multiply.
module muldiv_unit_div_core
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zero,
`ifdef MUL_ITER_EN
    input  logic             mul,
`endif
    input  logic             step,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quot,
    output logic             done
);
    localparam int CW = $clog2(STEPS + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs, rem_nx, quot_nx;
    logic [WIDTH:0]   sh, diff;

    assign sh   = {rem, quot[WIDTH-1]};
    assign diff = sh - {1'b0, dvs};

`ifdef MUL_ITER_EN
    logic           mode;
    logic [WIDTH:0] sum;
    // Multiply keeps the accumulator in rem and shifts product bits down into quot.
    assign sum     = {1'b0, rem} + (quot[0] ? {1'b0, dvs} : '0);
    assign rem_nx  = mode ? sum[WIDTH:1] : diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_nx = mode ? {sum[0], quot[WIDTH-1:1]} : {quot[WIDTH-2:0], ~diff[WIDTH]};
`else
    assign rem_nx  = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_nx = {quot[WIDTH-2:0], ~diff[WIDTH]};
`endif

    assign done = step & (cnt == CW'(STEPS - 1));

    // A zero divisor preloads the architectural result so no iteration is needed.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt  <= '0;
            rem  <= '0;
            quot <= '0;
            dvs  <= '0;
`ifdef MUL_ITER_EN
            mode <= 1'b0;
`endif
        end else if (start) begin
            cnt  <= '0;
            rem  <= zero ? a : '0;
            quot <= zero ? '1 : a;
            dvs  <= b;
`ifdef MUL_ITER_EN
            mode <= mul;
`endif
        end else if (step) begin
            cnt  <= cnt + 1'b1;
            rem  <= rem_nx;
            quot <= quot_nx;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: EX-stage multiply/divide unit producing HI/LO writes and a divide stall.
// Define MUL_ITER_EN to replace the single-cycle multiplier with a 32-step iterative one.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             stallreq,
    output logic             busy
);
    state_t             state;
    logic               start, is_div, is_mul, sgn, dz, iter_go, step, done;
    logic               neg_q, neg_r, fin, mfin, mnow, mul_wr, mthi, mtlo;
    logic [WIDTH-1:0]   a_in, b_in, rem, quot;
    logic [2*WIDTH-1:0] mres;

    assign start  = ex_valid & ~flush & (state == IDLE);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
    assign sgn    = (op == MD_DIV) || (op == MD_MULT);
    assign dz     = is_div & (src_b == '0);
    assign mthi   = start & (op == MD_MTHI);
    assign mtlo   = start & (op == MD_MTLO);
    // Signed ops iterate on magnitudes; divide-by-zero keeps the raw dividend for HI.
    assign a_in   = (sgn && !dz && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_in   = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    assign fin    = ex_valid & ~flush & (state == DIV_DONE);

`ifdef MUL_ITER_EN
    assign iter_go = start & (is_div | is_mul);
    assign step    = (state == DIV_BUSY) || (state == MUL_BUSY);
    assign mfin    = ex_valid & ~flush & (state == MUL_DONE);
    assign mnow    = 1'b0;
    assign mres    = neg_q ? -{rem, quot} : {rem, quot};
`else
    assign iter_go = start & is_div;
    assign step    = state == DIV_BUSY;
    assign mfin    = 1'b0;
    assign mnow    = start & is_mul;
    assign mres    = {{WIDTH{sgn & src_a[WIDTH-1]}}, src_a} * {{WIDTH{sgn & src_b[WIDTH-1]}}, src_b};
`endif

    assign mul_wr   = mfin | mnow;
    assign hi_we    = fin | mul_wr | mthi;
    assign lo_we    = fin | mul_wr | mtlo;
    assign hi_out   = fin ? (neg_r ? -rem : rem) : mul_wr ? mres[2*WIDTH-1:WIDTH] : mthi ? src_a : '0;
    assign lo_out   = fin ? (neg_q ? -quot : quot) : mul_wr ? mres[WIDTH-1:0] : mtlo ? src_a : '0;
    assign stallreq = ~flush & (iter_go | step);
    assign busy     = state != IDLE;

    muldiv_unit_div_core #(.WIDTH(WIDTH), .STEPS(DIV_STEPS)) u_core (
        .clk  (clk),
        .rst  (rst),
        .start(iter_go),
        .zero (dz),
`ifdef MUL_ITER_EN
        .mul  (is_mul),
`endif
        .step (step),
        .abort(flush),
        .a    (a_in),
        .b    (b_in),
        .rem  (rem),
        .quot (quot),
        .done (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (iter_go) begin
`ifdef MUL_ITER_EN
                    state <= is_mul ? MUL_BUSY : dz ? DIV_DONE : DIV_BUSY;
`else
                    state <= dz ? DIV_DONE : DIV_BUSY;
`endif
                    neg_q <= sgn & ~dz & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    neg_r <= sgn & is_div & ~dz & src_a[WIDTH-1];
                end
                DIV_BUSY: if (done) state <= DIV_DONE;
`ifdef MUL_ITER_EN
                MUL_BUSY: if (done) state <= MUL_DONE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ex_valid, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        hi_we, lo_we, stallreq, busy;
    logic [31:0] hi_out, lo_out;
    int          n_tests = 0;
    int          n_fail = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
        .hi_out(hi_out), .lo_out(lo_out), .stallreq(stallreq), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      p, q, r;
        logic [63:0] u;
        hi = '0;
        lo = '0;
        case (o)
            MD_MULT: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            MD_MULTU: begin
                u  = {32'b0, a} * {32'b0, b};
                hi = u[63:32];
                lo = u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (b == 0) begin
                    hi = a;
                    lo = '1;
                end else begin
                    q  = (o == MD_DIV) ? longint'($signed(a)) / longint'($signed(b))
                                       : longint'({32'b0, a}) / longint'({32'b0, b});
                    r  = (o == MD_DIV) ? longint'($signed(a)) % longint'($signed(b))
                                       : longint'({32'b0, a}) % longint'({32'b0, b});
                    hi = r[31:0];
                    lo = q[31:0];
                end
            end
            MD_MTHI: hi = a;
            MD_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, 32'({hi_we, lo_we}), 32'd0);
        check({tag, "_stall"}, 32'(stallreq), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int          stalls, exp_stalls;
        model(o, a, b, eh, el);
        exp_stalls = 0;
        if (o == MD_DIV || o == MD_DIVU) exp_stalls = (b == 0) ? 1 : 33;
`ifdef MUL_ITER_EN
        if (o == MD_MULT || o == MD_MULTU) exp_stalls = 33;
`endif
        @(posedge clk);
        #1;
        ex_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        stalls   = 0;
        @(negedge clk);
        while (stallreq === 1'b1 && stalls < 100) begin
            check("stall_no_we", 32'({hi_we, lo_we}), 32'd0);
            stalls++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("hi_we", 32'(hi_we), 32'(o != MD_MTLO));
        check("lo_we", 32'(lo_we), 32'(o != MD_MTHI));
        if (o != MD_MTLO) check("hi_out", hi_out, eh);
        if (o != MD_MTHI) check("lo_out", lo_out, el);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        op       = MD_NONE;
        @(negedge clk);
        check_quiet("after_op");
    endtask

    initial begin
        logic [2:0]  ops [6];
        logic [2:0]  o;
        logic [31:0] a, b;
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; op = MD_NONE; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_op(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        do_op(MD_DIVU, 32'd100, 32'd0);
        do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        do_op(MD_DIV, 32'd5, 32'd0);

        // Flush in the tenth busy cycle aborts without any write.
        @(posedge clk);
        #1;
        ex_valid = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
        repeat (10) begin
            @(negedge clk);
            check("flush_pre_stall", 32'(stallreq), 32'd1);
            check("flush_pre_we", 32'({hi_we, lo_we}), 32'd0);
        end
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(stallreq), 32'd0);
        check("flush_we", 32'({hi_we, lo_we}), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; ex_valid = 1'b0; op = MD_NONE;
        repeat (3) begin
            @(negedge clk);
            check_quiet("post_flush");
        end
        do_op(MD_DIVU, 32'd9, 32'd3);

        // Back-to-back MTHI then MTLO.
        @(posedge clk);
        #1;
        ex_valid = 1'b1; op = MD_MTHI; src_a = 32'h12345678; src_b = 32'h0;
        @(negedge clk);
        check("mthi_we", 32'({hi_we, lo_we}), 32'd2);
        check("mthi_data", hi_out, 32'h12345678);
        check("mthi_stall", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        op = MD_MTLO; src_a = 32'h9ABCDEF0;
        @(negedge clk);
        check("mtlo_we", 32'({hi_we, lo_we}), 32'd1);
        check("mtlo_data", lo_out, 32'h9ABCDEF0);

        // No-op and invalid cycles must not write.
        @(posedge clk);
        #1;
        op = MD_NONE; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        check_quiet("op_none");
        check("op_none_data", hi_out | lo_out, 32'd0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0; op = MD_MULT;
        @(negedge clk);
        check_quiet("invalid");

        // Reset mid-division discards everything.
        @(posedge clk);
        #1;
        ex_valid = 1'b1; op = MD_DIV; src_a = 32'd1000; src_b = 32'd3;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1; ex_valid = 1'b0; op = MD_NONE;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid_div");
        check("rst_mid_div_data", hi_out | lo_out, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 5)];
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op(o, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
